// File: rtl/fifo_sc_lvl.sv
// Single-clock FIFO with occupancy level, almost-full/empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN to build the first-word-fall-through read path (prefetch register).
module fifo_sc_lvl #(
  parameter int unsigned FIFO_DW = 32,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               push_i,
  input  logic [FIFO_DW-1:0] data_i,
  input  logic               pop_i,
  output logic [FIFO_DW-1:0] data_o,
  input  logic               flush_i,
  input  logic [FIFO_AW:0]   afull_thr_i,
  input  logic [FIFO_AW:0]   aempty_thr_i,
  input  logic               err_clr_i,
  output logic               empty_o,
  output logic               full_o,
  output logic               almost_full_o,
  output logic               almost_empty_o,
  output logic [FIFO_AW:0]   level_o,
  output logic               ovf_o,
  output logic               udf_o
);

  localparam int unsigned     Depth    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DepthLvl = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW:0] PtrOne   = (FIFO_AW + 1)'(1);

  logic [FIFO_DW-1:0] mem_q [Depth];

  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic [FIFO_DW-1:0] dout_q;

  logic empty;
  logic full;
  logic push_acc;
  logic pop_acc;
  logic ovf_set;
  logic udf_set;

  assign full     = (level_q == DepthLvl);
  assign push_acc = push_i & en_i & ~full & ~flush_i;
  assign pop_acc  = pop_i & en_i & ~empty & ~flush_i;
  // A push into a full FIFO is dropped even when a pop is accepted in the same cycle.
  assign ovf_set  = push_i & en_i & full & ~flush_i;
  assign udf_set  = pop_i & en_i & empty & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
    end else if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
  end

  always_comb begin
    level_d = level_q;
    if (flush_i) begin
      level_d = '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   level_d = level_q + PtrOne;
        2'b01:   level_d = level_q - PtrOne;
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
    if (udf_set) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is never reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= data_i;
    end
  end

`ifdef FIFO_FWFT_EN

  logic             head_vld_q, head_vld_d;
  logic [FIFO_AW:0] mem_cnt;
  logic             load;

  // The prefetch register counts toward level_q, so empty follows its valid bit.
  assign empty   = ~head_vld_q;
  assign mem_cnt = wr_ptr_q - rd_ptr_q;
  assign load    = ~flush_i & (mem_cnt != '0) & (~head_vld_q | pop_acc);

  always_comb begin
    head_vld_d = head_vld_q;
    if (flush_i) begin
      head_vld_d = 1'b0;
    end else if (load) begin
      head_vld_d = 1'b1;
    end else if (pop_acc) begin
      head_vld_d = 1'b0;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      rd_ptr_d = '0;
    end else if (load) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_vld_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      head_vld_q <= head_vld_d;
      if (load) begin
        dout_q <= mem_q[rd_ptr_q[FIFO_AW-1:0]];
      end
    end
  end

`else

  logic               rd_en_q;
  logic [FIFO_AW-1:0] rd_addr_q;

  assign empty = (level_q == '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      rd_ptr_d = '0;
    end else if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  // Pop registers the address; the word lands on data_o on the following edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      dout_q    <= '0;
    end else begin
      rd_en_q   <= pop_acc;
      rd_addr_q <= rd_ptr_q[FIFO_AW-1:0];
      if (rd_en_q && !flush_i) begin
        dout_q <= mem_q[rd_addr_q];
      end
    end
  end

`endif

  assign data_o         = dout_q;
  assign empty_o        = empty;
  assign full_o         = full;
  assign level_o        = level_q;
  assign ovf_o          = ovf_q;
  assign udf_o          = udf_q;
  assign almost_full_o  = (level_q >= afull_thr_i);
  assign almost_empty_o = (level_q <= aempty_thr_i);

endmodule

// File: tb/tb_fifo_sc_lvl.sv
// Self-checking bench for fifo_sc_lvl (FIFO_AW = 2): table-driven vectors plus a queue model.
module tb_fifo_sc_lvl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        push;
  logic [31:0] din;
  logic        pop;
  logic [31:0] dout;
  logic        flush;
  logic [2:0]  afull_thr;
  logic [2:0]  aempty_thr;
  logic        err_clr;
  logic        empty;
  logic        full;
  logic        afull;
  logic        aempty;
  logic [2:0]  level;
  logic        ovf;
  logic        udf;

  fifo_sc_lvl #(
    .FIFO_DW(32),
    .FIFO_AW(2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .push_i        (push),
    .data_i        (din),
    .pop_i         (pop),
    .data_o        (dout),
    .flush_i       (flush),
    .afull_thr_i   (afull_thr),
    .aempty_thr_i  (aempty_thr),
    .err_clr_i     (err_clr),
    .empty_o       (empty),
    .full_o        (full),
    .almost_full_o (afull),
    .almost_empty_o(aempty),
    .level_o       (level),
    .ovf_o         (ovf),
    .udf_o         (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: the queue is the scoreboard of words in flight.
  logic [31:0] mq [$];
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;
  logic [31:0] exp_data = '0;
  logic [31:0] pend_data = '0;
  logic        pend_vld = 1'b0;

  typedef struct {
    logic        push;
    logic        pop;
    logic        flush;
    logic        clr;
    logic [31:0] din;
    int          exp_level;
    logic        exp_ovf;
    logic        exp_udf;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, then check outputs #1 after the edge.
  task automatic cyc(input logic p, input logic q, input logic f, input logic c,
                     input logic [31:0] d);
    bit          pacc;
    bit          qacc;
    bit          oset;
    bit          uset;
    logic [31:0] popped;
    push = p; pop = q; flush = f; err_clr = c; din = d;
    pacc   = p && en && !f && (mq.size() < 4);
    qacc   = q && en && !f && (mq.size() > 0);
    oset   = p && en && !f && (mq.size() == 4);
    uset   = q && en && !f && (mq.size() == 0);
    popped = '0;
    if (qacc) popped = mq.pop_front();
    if (pacc) mq.push_back(d);
    if (f) mq.delete();
    m_ovf = oset ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_udf = uset ? 1'b1 : (c ? 1'b0 : m_udf);
    @(posedge clk);
    #1;
    if (pend_vld && !f) exp_data = pend_data;
    pend_vld  = qacc;
    pend_data = popped;
    push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0; din = '0;
    chk("level", 32'(level), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == 4));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
    chk("almost_full", 32'(afull), 32'(mq.size() >= int'(afull_thr)));
    chk("almost_empty", 32'(aempty), 32'(mq.size() <= int'(aempty_thr)));
`ifndef FIFO_FWFT_EN
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("data", dout, exp_data);
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_udf"}, 32'(udf), 32'd0);
    chk({tag, "_data"}, dout, 32'd0);
    chk({tag, "_aempty"}, 32'(aempty), 32'd1);
    chk({tag, "_afull"}, 32'(afull), 32'(afull_thr == 3'd0));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
    din = '0; afull_thr = 3'd3; aempty_thr = 3'd1;

    // Fill/overflow, drain, then underflow with a simultaneous clear.
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 1, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 2, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 3, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd4, 4, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 4, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd6, 4, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 3, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 2, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 0, 1'b0, 1'b1};
    vt[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 0, 1'b0, 1'b1};
    vt[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cyc(vt[i].push, vt[i].pop, vt[i].flush, vt[i].clr, vt[i].din);
      chk("tbl_level", 32'(level), 32'(vt[i].exp_level));
      chk("tbl_ovf", 32'(ovf), 32'(vt[i].exp_ovf));
      chk("tbl_udf", 32'(udf), 32'(vt[i].exp_udf));
    end
`ifndef FIFO_FWFT_EN
    chk("udf_data_hold", dout, 32'd4);
`endif

    // Disabled FIFO ignores requests and raises no errors.
    en = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    en = 1'b1;

    // Wrap-around: steady push+pop at level 2.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0A);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0B);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h10 + 32'(i));
      chk("wrap_level", 32'(level), 32'd2);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifndef FIFO_FWFT_EN
    chk("wrap_last", dout, 32'h19);
`endif

    // Flush at level 3 with a concurrent push.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h31 + 32'(i));
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h77);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ovf", 32'(ovf), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hA5);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifndef FIFO_FWFT_EN
    chk("flush_then_a5", dout, 32'hA5);
`endif

    // Thresholds, including a live threshold change at level 2.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h41);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h42);
    afull_thr = 3'd2;
    #1;
    chk("afull_thr_live_on", 32'(afull), 32'd1);
    afull_thr = 3'd3;
    #1;
    chk("afull_thr_live_off", 32'(afull), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h43);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h44);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset mid-operation at level 3 with a sticky flag set.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h51 + 32'(i));
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    mq.delete();
    m_ovf = 1'b0; m_udf = 1'b0; exp_data = '0; pend_vld = 1'b0; pend_data = '0;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h5);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifndef FIFO_FWFT_EN
    chk("post_reset_data", dout, 32'h5);
`endif

`ifdef FIFO_FWFT_EN
    // Head word falls through two edges after a push into an empty FIFO.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hC3);
    chk("fwft_still_empty", 32'(empty), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("fwft_empty_n", 32'(empty), 32'd0);
    chk("fwft_data", dout, 32'hC3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("fwft_drained", 32'(empty), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_sc_lvl.md
# fifo_sc_lvl

Single-clock, parametrised BRAM-backed FIFO. It is the single-domain successor of the dual-clock processor FIFO and is used wherever producer and consumer already share one clock (tProc internal queues, port staging). It adds the following over the previous generation:
- occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow flags;
- an optional first-word-fall-through read mode.

## Interface
Parameters:
- FIFO_DW, default 32: data width in bits.
- FIFO_AW, default 4: address width. Depth is 2^FIFO_AW words.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  FIFO enable. When low, push and pop are ignored and no error flags are set.
- push_i  in  1  write request.
- data_i  in  FIFO_DW  write data.
- pop_i  in  1  read request.
- data_o  out  FIFO_DW  read data.
- flush_i  in  1  synchronous clear. Acts regardless of en_i.
- afull_thr_i  in  FIFO_AW+1  almost-full threshold.
- aempty_thr_i  in  FIFO_AW+1  almost-empty threshold.
- err_clr_i  in  1  clears ovf_o and udf_o.
- empty_o  out  1  no word readable.
- full_o  out  1  level_o == 2^FIFO_AW.
- almost_full_o  out  1  level_o >= afull_thr_i.
- almost_empty_o  out  1  level_o <= aempty_thr_i.
- level_o  out  FIFO_AW+1  stored word count, 0..2^FIFO_AW.
- ovf_o  out  1  sticky: a push was dropped.
- udf_o  out  1  sticky: a pop was made on empty.

## Operation
- Storage is a 2^FIFO_AW x FIFO_DW memory with synchronous read.
- Write and read pointers are FIFO_AW+1 bits wide. The MSB disambiguates full from empty. Pointers wrap modulo 2^(FIFO_AW+1).
- Accepted push: push_i & en_i & !full_o & !flush_i. It writes data_i at wr_ptr, then wr_ptr+1.
- Accepted pop: pop_i & en_i & !empty_o & !flush_i. It advances rd_ptr.
- Push while full_o: the word is dropped and ovf_o is set. This applies even if a pop is accepted in the same cycle.
- Pop while empty_o: ignored, udf_o is set, data_o is unchanged.
- Simultaneous accepted push and pop: both occur and level_o is unchanged.
- level_o updates as +1 on push only, -1 on pop only, and is unchanged for both or neither. It never exceeds 2^FIFO_AW or goes below 0.
- flush_i has highest priority:
  - Pointers and level_o are set to 0 and empty_o is set to 1.
  - Any push or pop in the same cycle is discarded and does not set error flags.
  - data_o holds its value.
  - ovf_o and udf_o are unaffected.
- Error flags:
  - ovf_o and udf_o stay set until err_clr_i.
  - If a set and err_clr_i occur in the same cycle, the set wins.
- almost_full_o and almost_empty_o are combinational compares against the registered level_o and the threshold inputs. Threshold changes take effect immediately.

## Timing
- Values after reset:
  - level_o = 0, empty_o = 1, full_o = 0.
  - ovf_o = 0, udf_o = 0, data_o = 0.
  - almost_empty_o = 1.
  - almost_full_o = (afull_thr_i == 0).
- Standard mode:
  - A push accepted at edge N makes empty_o = 0 and updates level_o after edge N.
  - A pop accepted at edge N presents the word on data_o after edge N+1 (latency 1). data_o holds until the next accepted pop.
- full_o deasserts after the edge where a pop is accepted.
- Reset asserted mid-operation:
  - All state clears immediately.
  - Memory contents are not cleared but are unreachable.

## Configuration
- FIFO_FWFT_EN defined (first-word-fall-through):
  - The head word is presented on data_o whenever empty_o = 0.
  - An accepted pop at edge N shows the next word on data_o after edge N, or sets empty_o if the FIFO becomes empty.
  - For a push at edge N into an empty FIFO, empty_o deasserts and data_o is valid after edge N+1. level_o increments after edge N.
  - Capacity stays 2^FIFO_AW. The prefetch register is counted in level_o.
  - Flush invalidates the prefetch register.
- FIFO_FWFT_EN undefined: standard mode as above. No prefetch logic is built.

## Test plan
All scenarios use FIFO_AW = 2, FIFO_DW = 32.
- Fill and overflow: push 1..6 back-to-back, en_i = 1.
  - full_o and level_o = 4 after the 4th push; ovf_o = 1 after the 5th push.
  - Four pops then return 1, 2, 3, 4 on data_o, each one cycle after its pop.
  - empty_o = 1 afterwards; err_clr_i drops ovf_o.
- Underflow: pop on an empty FIFO holding data_o = 4.
  - udf_o = 1, data_o stays 4, level_o stays 0.
  - err_clr_i asserted in the same cycle as a second empty pop leaves udf_o = 1.
- Wrap-around: at level 2, assert push and pop together for 10 cycles with data 0x10..0x19.
  - level_o stays 2 throughout.
  - Pops return words in exact push order across pointer wrap.
- Flush: at level 3, assert flush_i with push_i (data 0x77).
  - Next cycle: level_o = 0, empty_o = 1, ovf_o = 0.
  - Then push 0xA5 and pop: data_o = 0xA5.
- Thresholds: afull_thr_i = 3, aempty_thr_i = 1, push to 4 then pop to 0.
  - almost_empty_o is 1 at levels 0–1.
  - almost_full_o is 1 at levels 3–4.
  - Changing afull_thr_i to 2 at level 2 asserts almost_full_o the same cycle.
- Reset and FWFT:
  - Reset at level 3: all outputs return to their reset values, then a push/pop of 0x5 returns 0x5.
  - With FIFO_FWFT_EN: a push of 0xC3 into an empty FIFO shows data_o = 0xC3 with empty_o = 0 two edges later, before any pop.
